// File: rtl/mult_arbiter.sv
// mult_arbiter: shares one signed 4x4 multiplier between two requesters.
// A winner's factors are latched, held for CALC_CYCLES cycles, and the
// product is returned on that port through a valid/take handshake.
// Optional feature macro: MULT_ARB_ROUND_ROBIN_EN selects round-robin
// arbitration; when it is undefined, port 0 has fixed priority.

module four_bit_multiplier (
  input  logic signed [3:0] factor1,
  input  logic signed [3:0] factor2,
  output logic signed [7:0] out
);

  logic signed [7:0] a_ext;
  logic signed [7:0] b_ext;

  assign a_ext = {{4{factor1[3]}}, factor1};
  assign b_ext = {{4{factor2[3]}}, factor2};
  assign out   = a_ext * b_ext;

endmodule

module mult_arbiter #(
  parameter int CALC_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       req1,
  input  logic [3:0] factor1_0,
  input  logic [3:0] factor2_0,
  input  logic [3:0] factor1_1,
  input  logic [3:0] factor2_1,
  output logic       grant0,
  output logic       grant1,
  output logic       valid0,
  output logic       valid1,
  output logic [7:0] result0,
  output logic [7:0] result1,
  input  logic       take0,
  input  logic       take1,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

  localparam logic [3:0] CNT_INIT = 4'(CALC_CYCLES);

  state_t     state;
  state_t     next_state;
  logic [3:0] op_a;
  logic [3:0] op_b;
  logic [3:0] cnt;
  logic       owner;
  logic       winner;
  logic       any_req;
  logic       owner_take;
  logic       owner_valid;
  logic       load;
  logic       capture;
  logic       release_op;
  logic [7:0] product;

`ifdef MULT_ARB_ROUND_ROBIN_EN
  logic       last;
`endif

  four_bit_multiplier u_mult (
    .factor1 (op_a),
    .factor2 (op_b),
    .out     (product)
  );

  assign any_req     = req0 | req1;
  assign owner_take  = owner ? take1 : take0;
  assign owner_valid = owner ? valid1 : valid0;

  // Arbitration: pick the winning port among pending requests.
  always_comb begin
`ifdef MULT_ARB_ROUND_ROBIN_EN
    if (req0 && req1) winner = ~last;
    else              winner = req1;
`else
    winner = ~req0;
`endif
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (any_req) next_state = CALC;
      CALC: if (cnt <= 4'd1) next_state = RESP;
      RESP: if (owner_take && owner_valid) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output decode: strobes that steer the datapath registers, plus busy.
  always_comb begin
    load       = (state == IDLE) && any_req;
    capture    = (state == CALC) && (cnt <= 4'd1);
    release_op = (state == RESP) && owner_take && owner_valid;
    busy       = (state != IDLE);
  end

  // Latch the winner's factors and remember which port owns the multiplier.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a  <= 4'd0;
      op_b  <= 4'd0;
      owner <= 1'b0;
    end else if (load) begin
      op_a  <= winner ? factor1_1 : factor1_0;
      op_b  <= winner ? factor2_1 : factor2_0;
      owner <= winner;
    end
  end

  // One-cycle grant pulse on the edge the factors are latched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant0 <= 1'b0;
      grant1 <= 1'b0;
    end else begin
      grant0 <= load && !winner;
      grant1 <= load && winner;
    end
  end

  // Settling-window counter: loaded on grant, counts down while in CALC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= 4'd0;
    end else if (load) begin
      cnt <= CNT_INIT;
    end else if ((state == CALC) && (cnt > 4'd1)) begin
      cnt <= cnt - 4'd1;
    end
  end

  // Capture the product into the owner's result register and hold valid until taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result0 <= 8'd0;
      result1 <= 8'd0;
      valid0  <= 1'b0;
      valid1  <= 1'b0;
    end else if (capture) begin
      if (owner) begin
        result1 <= product;
        valid1  <= 1'b1;
      end else begin
        result0 <= product;
        valid0  <= 1'b1;
      end
    end else if (release_op) begin
      if (owner) valid1 <= 1'b0;
      else       valid0 <= 1'b0;
    end
  end

`ifdef MULT_ARB_ROUND_ROBIN_EN
  // Remember the most recently served port; reset favours port 0 first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             last <= 1'b1;
    else if (release_op) last <= owner;
  end
`endif

endmodule

// File: doc/mult_arbiter.md
# mult_arbiter

Two-port arbiter and sequencer that shares one `four_bit_multiplier` instance between two requesters in the calculator datapath. It selects a winner among the pending requests and latches that winner's signed 4-bit factors into operand registers. It holds the operands stable for a programmable settling window, then captures the signed 8-bit product into a per-port result register. The product is returned to the winner through a valid/take handshake.

## Interface
- `CALC_CYCLES`, default 1: cycles the operand registers are held before the product is captured. Legal range 1..15.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req0` / `req1`  in  1  request from port 0 / port 1. Held high with factors stable until grant.
- `factor1_0`, `factor2_0` / `factor1_1`, `factor2_1`  in  4 each  signed two's-complement factors per port.
- `grant0` / `grant1`  out  1  one-cycle pulse. Factors of that port were latched on the preceding edge.
- `valid0` / `valid1`  out  1  result available on the matching port. Held until taken.
- `result0` / `result1`  out  8  signed product. Holds its last captured value.
- `take0` / `take1`  in  1  result consumed. Effective only while the matching valid is high.
- `busy`  out  1  high in every state except IDLE.

## Operation
- Internal state:
  - FSM states: IDLE, CALC, RESP.
  - 4-bit operand registers `op_a`, `op_b`.
  - 1-bit `owner`.
  - 1-bit `last` (port served most recently).
  - 4-bit down-counter `cnt`.
- `op_a`/`op_b` drive the multiplier's `factor1`/`factor2`. The multiplier's `out` feeds the result capture.
- IDLE:
  - No request pending: remain in IDLE.
  - A request pending: choose a winner, latch its factors into `op_a`/`op_b`, set `owner`, load `cnt` = CALC_CYCLES, pulse the winner's grant for the next cycle, and go to CALC.
- CALC:
  - `cnt` > 1: decrement.
  - `cnt` == 1: write the multiplier output into `result<owner>`, set `valid<owner>`, and go to RESP.
- RESP:
  - Edge with `take<owner>` high: clear `valid<owner>`, set `last` = `owner`, and go to IDLE.
  - `take` on the non-owner port is ignored. A `take` while valid is low is ignored.
- Request rules:
  - Requests arriving outside IDLE are not queued. They wait, and are re-evaluated in the next IDLE cycle.
  - A request that drops before its grant is withdrawn with no side effect.
  - A request held high after its grant is treated as a new request.
- Arithmetic:
  - Operands are signed 4-bit (−8..7). The product is signed 8-bit (−56..64) and exact for all 256 operand pairs.
  - Example: −8 × −8 = 0x40.
  - No overflow flag exists.
- Reset, asserted at any time including mid-CALC or mid-RESP:
  - State returns to IDLE and any in-flight operation is discarded.
  - Cleared to 0: `op_a`, `op_b`, `cnt`, `owner`, `valid0`, `valid1`, `grant0`, `grant1`, `busy`, `result0`, `result1`.
  - `last` is set to 1, so port 0 wins first.

## Timing
- Edge E0: winner latched. Grant is high during cycle E0..E1.
- Edge E_CALC_CYCLES: result captured. Valid is high from this edge.
- Earliest take edge is E_CALC_CYCLES+1. Earliest next grant-latch edge is E_CALC_CYCLES+2.
- With CALC_CYCLES = 1: grant after E0, valid after E1, IDLE after E2, next latch at E3. Minimum 3 cycles per operation.
- Grant and valid are registered outputs. No combinational path runs from any input to any output.
- Valid is never high on both ports at once.

## Configuration
- `MULT_ARB_ROUND_ROBIN_EN`
  - Defined: round-robin arbitration. When both ports request, the port ≠ `last` wins. A single requester always wins.
  - Undefined: fixed priority, port 0 always wins when both ports request, and `last` is unused. Port 1 can starve; this is accepted behaviour.

## Test plan
- Single request, CALC_CYCLES=1: port 0 requests 3 × 5 → `grant0` pulses after E0, `valid0` high after E1 with `result0` = 0x0F, and `take0` at E2 returns the block to IDLE with `busy` = 0.
- Sign cases: −3 × 5 → 0xF1; −8 × −8 → 0x40; −8 × 7 → 0xC8; 0 × −1 → 0x00.
- Contention:
  - Round robin defined: `req0` and `req1` held continuously → grant order port 0, 1, 0, 1.
  - Macro undefined: same stimulus → grants go to port 0 only.
- Latency and hold: CALC_CYCLES=3, `take` delayed 5 cycles → valid rises exactly 3 edges after the latch edge, `result` stays stable while waiting, and a `take` on the wrong port has no effect.
- Reset mid-operation: `rst` pulsed during CALC → all outputs 0 and `busy` = 0. A subsequent simultaneous request is granted to port 0.
- Withdrawal: `req1` pulses for one cycle while the block is busy serving port 0 → no `grant1` and no `valid1` is ever produced.
